ps2_kbd_event_ctrl: RTL and testbench
=====================================

Name: ps2_kbd_event_ctrl

Overview:
- Sits downstream of the PS/2 keyboard byte receiver and sequences its output bytes (one-cycle done pulse plus 8-bit data) into complete Scan Code Set 2 key events.
- Handles the E0 (extended), F0 (break) and E1 (pause) prefix sequences, and filters keyboard status bytes into sticky flags.
- Queues events in a small FIFO with a valid/ready handshake.
- Maintains a held-key bitmap for the motor-tracking jog keys (arrows and space).

Parameters:
- FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, at least 2.
- TIMEOUT_CYCLES, 2_000_000, maximum clk cycles allowed between bytes of one multi-byte code (20 ms at 100 MHz).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- rx_done  in  1  single-cycle pulse: a new byte is valid on rx_data.
- rx_data  in  8  received byte; sampled only when rx_done=1.
- ev_valid  out  1  FIFO head event available.
- ev_ready  in  1  consumer accepts the head event; a pop occurs when ev_valid&ev_ready.
- ev_code  out  8  final scan code byte of the head event.
- ev_ext  out  1  head event carried the E0 prefix.
- ev_break  out  1  head event is a release (carried F0).
- key_state  out  5  held keys: [0]=up (E0 75), [1]=down (E0 72), [2]=left (E0 6B), [3]=right (E0 74), [4]=space (29).
- bat_ok  out  1  sticky: 0xAA received.
- err_flags  out  4  sticky: [0]=FIFO overflow, [1]=inter-byte timeout, [2]=BAT fail (FC/FD), [3]=keyboard overrun (00/FF).
- clr_status  in  1  pulse: clears bat_ok and err_flags.

Behaviour:
- Reset (reset_n=0, asynchronous): FSM returns to S_IDLE. The FIFO empties. All outputs go to 0: ev_valid, ev_code, ev_ext, ev_break, key_state, bat_ok, err_flags. The timeout counter goes to 0.
- FSM states and transitions (each transition evaluated on an rx_done pulse):
  - S_IDLE:
    - E0 → S_EXT.
    - F0 → S_BRK with ext=0.
    - E1 → S_SKIP with skip_cnt=7.
    - AA → set bat_ok.
    - FA, FE → ignored.
    - FC, FD → set err_flags[2].
    - 00, FF → set err_flags[3].
    - Any other byte → push a make event {code, ext=0, break=0}.
  - S_EXT:
    - F0 → S_BRK with ext=1.
    - Other byte → push {code, ext=1, break=0}, then → S_IDLE.
    - E0/E1 received here → treated as a code byte (no special handling).
  - S_BRK: any byte → push {code, ext, break=1}, then → S_IDLE.
  - S_SKIP: each byte decrements skip_cnt; at 0 → push {code=0x77, ext=1, break=0} (the pause event), then → S_IDLE.
- Timeout:
  - The counter runs only while the FSM is outside S_IDLE, and clears on every rx_done.
  - On reaching TIMEOUT_CYCLES-1: → S_IDLE, set err_flags[1], discard the partial code. No event is pushed.
- Latency:
  - FSM update and FIFO write occur on the clk edge where rx_done=1.
  - ev_valid is registered; it is high in the following cycle when the FIFO was empty.
  - key_state updates on the same edge as the push.
- FIFO:
  - The head is presented combinationally from storage; ev_* stay stable while ev_valid=1 and ev_ready=0.
  - Push is accepted when count<FIFO_DEPTH, or when a pop occurs in the same cycle (simultaneous push+pop when full keeps count=FIFO_DEPTH).
  - Otherwise the push is dropped and err_flags[0] is set.
  - Pointers are log2(FIFO_DEPTH) bits wide and wrap naturally. The count is one bit wider.
  - Pop on empty is ignored.
- key_state:
  - A make event for a mapped key sets its bit; the break event clears it.
  - key_state updates even when the FIFO push is dropped.
  - Unmapped codes leave key_state unchanged.
- Sticky flags:
  - Set and clear are synchronous.
  - clr_status wins over a same-cycle set, except that a set in the same cycle as clr_status is lost.
  - FIFO contents and key_state are unaffected by clr_status.
- Mid-sequence reset: the partial code is discarded. The next byte is decoded from S_IDLE.

Decomposition:
- Package ps2_kbd_pkg holds:
  - Prefix/status byte constants: E0, F0, E1, AA, FA, FE, FC, FD, 00, FF.
  - The jog-key code constants.
  - The FSM state encoding (S_IDLE, S_EXT, S_BRK, S_SKIP).
  - The event struct width (10 bits: code, ext, break).
- Sub-module ps2_event_fifo (parameterised depth, synchronous FIFO with count/full/empty) is instantiated once.

Test Plan:
- Bytes 1C, then F0 1C, with ev_ready=1 → two events: {1C,ext0,brk0} then {1C,ext0,brk1}. ev_valid is high one cycle after each final rx_done.
- Bytes E0 75, then E0 F0 75 → key_state[0] rises after the byte 75 of the first sequence and falls after the final 75. Events are {75,1,0} and {75,1,1}.
- ev_ready=0 with 5 make codes (15,1D,24,2D,2C) → first 4 queued, err_flags[0]=1. Releasing ev_ready drains 15,1D,24,2D in order.
- E0, then no byte for TIMEOUT_CYCLES (bench override 100) → err_flags[1]=1, no event. A following 29 gives {29,0,0} and key_state[4]=1.
- Bytes AA, FC, 00 → bat_ok=1, err_flags=4'b1100, no events. A clr_status pulse → all clear.
- E1 14 77 E1 F0 14 F0 77 → exactly one event, {77,1,0}. Then assert reset_n=0 after an E0 F0 → all outputs 0; the next byte 1C yields {1C,0,0}.

Source files
------------

// File: rtl/ps2_kbd_pkg.sv
// -----------------------------------------------------------------------------
// ps2_kbd_pkg
// Shared definitions for the PS/2 keyboard event controller:
//   - Scan Code Set 2 prefix and status byte constants
//   - jog-key scan codes and the key_state bit mapping helper
//   - FSM state encoding and the 10-bit queued event record
// -----------------------------------------------------------------------------
package ps2_kbd_pkg;

  // Prefix bytes
  localparam logic [7:0] CODE_E0 = 8'hE0;  // extended prefix
  localparam logic [7:0] CODE_F0 = 8'hF0;  // break prefix
  localparam logic [7:0] CODE_E1 = 8'hE1;  // pause sequence prefix

  // Keyboard status / reply bytes
  localparam logic [7:0] CODE_AA = 8'hAA;  // BAT passed
  localparam logic [7:0] CODE_FA = 8'hFA;  // ACK
  localparam logic [7:0] CODE_FE = 8'hFE;  // resend request
  localparam logic [7:0] CODE_FC = 8'hFC;  // BAT failed
  localparam logic [7:0] CODE_FD = 8'hFD;  // BAT failed (alternate)
  localparam logic [7:0] CODE_00 = 8'h00;  // key detection error / overrun
  localparam logic [7:0] CODE_FF = 8'hFF;  // key detection error / overrun

  // Jog keys (arrows carry E0, space does not)
  localparam logic [7:0] KEY_UP     = 8'h75;
  localparam logic [7:0] KEY_DOWN   = 8'h72;
  localparam logic [7:0] KEY_LEFT   = 8'h6B;
  localparam logic [7:0] KEY_RIGHT  = 8'h74;
  localparam logic [7:0] KEY_SPACE  = 8'h29;

  // The 8-byte pause sequence is reported as a single extended 77 make
  localparam logic [7:0] PAUSE_CODE = 8'h77;
  localparam logic [2:0] SKIP_LEN   = 3'd7;  // bytes following E1

  localparam int EVENT_W = 10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXT  = 2'd1,
    S_BRK  = 2'd2,
    S_SKIP = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
  } kbd_event_t;

  // One-hot key_state bit for a jog key, zero for anything else.
  function automatic logic [4:0] jog_mask(input logic [7:0] code, input logic ext);
    logic [4:0] m;
    m = '0;
    if (ext) begin
      case (code)
        KEY_UP:    m[0] = 1'b1;
        KEY_DOWN:  m[1] = 1'b1;
        KEY_LEFT:  m[2] = 1'b1;
        KEY_RIGHT: m[3] = 1'b1;
        default:   m = '0;
      endcase
    end else if (code == KEY_SPACE) begin
      m[4] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// -----------------------------------------------------------------------------
// ps2_event_fifo
// Synchronous FIFO with a combinational head (first-word fall-through).
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : write request and data; accepted when not full, or when a
//                  pop happens in the same cycle
//   pop          : read request; ignored when empty
//   dout         : head entry, forced to 0 while empty
//   count        : occupancy (one bit wider than the pointers)
//   empty        : count == 0
// -----------------------------------------------------------------------------
module ps2_event_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees the slot this same edge, so a full FIFO can still take a push.
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; only the pointers and count define
  // which entries are live, and dout is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ps2_kbd_event_ctrl.sv
// -----------------------------------------------------------------------------
// ps2_kbd_event_ctrl
// Assembles PS/2 Scan Code Set 2 bytes into key events and queues them.
//   clk, reset_n      : clock, asynchronous active-low reset
//   rx_done, rx_data  : one-cycle byte strobe and byte from the PS/2 receiver
//   ev_valid/ev_ready : event queue handshake (pop on valid & ready)
//   ev_code/ext/break : head event fields
//   key_state         : held jog keys {space, right, left, down, up}
//   bat_ok            : sticky, BAT-passed byte seen
//   err_flags         : sticky {overrun, BAT fail, inter-byte timeout, overflow}
//   clr_status        : clears bat_ok and err_flags
// -----------------------------------------------------------------------------
module ps2_kbd_event_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_break,
  output logic [4:0] key_state,
  output logic       bat_ok,
  output logic [3:0] err_flags,
  input  logic       clr_status
);

  localparam int CW   = $clog2(FIFO_DEPTH) + 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  state_e          state, state_nxt;
  logic [2:0]      skip_cnt, skip_nxt;
  logic            ext_q, ext_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            timeout_hit;

  logic            push;
  kbd_event_t      push_ev;
  kbd_event_t      head_ev;
  logic            pop;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            overflow;
  logic            set_bat;
  logic [3:0]      set_err;
  logic [4:0]      push_mask;

  assign timeout_hit = (state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statements can leave a value held (which would infer a latch).
  always_comb begin
    state_nxt    = state;
    skip_nxt     = skip_cnt;
    ext_nxt      = ext_q;
    push         = 1'b0;
    push_ev.code = rx_data;
    push_ev.ext  = 1'b0;
    push_ev.brk  = 1'b0;
    set_bat      = 1'b0;
    set_err      = '0;

    if (rx_done) begin
      case (state)
        S_IDLE: begin
          case (rx_data)
            CODE_E0: state_nxt = S_EXT;
            CODE_F0: begin
              state_nxt = S_BRK;
              ext_nxt   = 1'b0;
            end
            CODE_E1: begin
              state_nxt = S_SKIP;
              skip_nxt  = SKIP_LEN;
            end
            CODE_AA:          set_bat    = 1'b1;
            CODE_FA, CODE_FE: set_bat    = 1'b0;
            CODE_FC, CODE_FD: set_err[2] = 1'b1;
            CODE_00, CODE_FF: set_err[3] = 1'b1;
            default:          push       = 1'b1;
          endcase
        end
        S_EXT: begin
          if (rx_data == CODE_F0) begin
            state_nxt = S_BRK;
            ext_nxt   = 1'b1;
          end else begin
            push        = 1'b1;
            push_ev.ext = 1'b1;
            state_nxt   = S_IDLE;
          end
        end
        S_BRK: begin
          push        = 1'b1;
          push_ev.ext = ext_q;
          push_ev.brk = 1'b1;
          state_nxt   = S_IDLE;
        end
        S_SKIP: begin
          // The last pause byte arrives with skip_cnt at 1 and takes it to 0.
          skip_nxt = skip_cnt - 1'b1;
          if (skip_cnt == 3'd1) begin
            push         = 1'b1;
            push_ev.code = PAUSE_CODE;
            push_ev.ext  = 1'b1;
            state_nxt    = S_IDLE;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_nxt  = S_IDLE;
      set_err[1] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      skip_cnt <= '0;
      ext_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
      ext_q    <= ext_nxt;
    end
  end

  // Inter-byte timer: idle in S_IDLE, restarted by every byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt <= '0;
    end else if (rx_done || state == S_IDLE || timeout_hit) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign pop      = ev_valid & ev_ready;
  assign overflow = push && (fifo_count == CW'(FIFO_DEPTH)) && !pop;

  ps2_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (push_ev),
    .pop     (pop),
    .dout    (head_ev),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign ev_code  = head_ev.code;
  assign ev_ext   = head_ev.ext;
  assign ev_break = head_ev.brk;

  // Held keys follow the decoded event even when the queue drops it.
  assign push_mask = jog_mask(push_ev.code, push_ev.ext);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      key_state <= '0;
    end else if (push) begin
      if (push_ev.brk) key_state <= key_state & ~push_mask;
      else             key_state <= key_state | push_mask;
    end
  end

  // Sticky status: a clear discards any set arriving in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bat_ok    <= 1'b0;
      err_flags <= '0;
    end else if (clr_status) begin
      bat_ok    <= 1'b0;
      err_flags <= '0;
    end else begin
      bat_ok    <= bat_ok | set_bat;
      err_flags <= err_flags | set_err | {3'b000, overflow};
    end
  end

endmodule

// File: tb/tb_ps2_kbd_event_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_event_ctrl
// Self-checking bench: directed scenarios followed by randomized key traffic
// with a randomly stalling consumer. Expected events are derived from the
// transaction being sent (key, extended?, release?) and tracked in a queue
// with the FIFO capacity rule applied; held keys and sticky flags are kept in
// a small model alongside.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_event_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 100;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       clr_status = 1'b0;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic [4:0] key_state;
  logic       bat_ok;
  logic [3:0] err_flags;

  ps2_kbd_event_ctrl #(
    .FIFO_DEPTH     (DEPTH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_code    (ev_code),
    .ev_ext     (ev_ext),
    .ev_break   (ev_break),
    .key_state  (key_state),
    .bat_ok     (bat_ok),
    .err_flags  (err_flags),
    .clr_status (clr_status)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic [9:0] exp_q[$];        // {code, ext, brk}
  logic [4:0] exp_keys = '0;
  logic       exp_bat  = 1'b0;
  logic [3:0] exp_err  = '0;

  logic       mon_push = 1'b0; // byte on rx_data completes an event
  logic [9:0] mon_ev   = '0;
  bit         rand_ready = 1'b0;
  int         mon_k;

  function automatic logic [9:0] ev(input logic [7:0] code, input logic ext, input logic brk);
    return {code, ext, brk};
  endfunction

  // key_state bit of a jog key, -1 otherwise
  function automatic int key_index(input logic [9:0] e);
    if (e[1] && e[9:2] == 8'h75)  return 0;
    if (e[1] && e[9:2] == 8'h72)  return 1;
    if (e[1] && e[9:2] == 8'h6B)  return 2;
    if (e[1] && e[9:2] == 8'h74)  return 3;
    if (!e[1] && e[9:2] == 8'h29) return 4;
    return -1;
  endfunction

  // Cycle monitor at the falling edge: compares against the model state of
  // the previous rising edge, then applies what the coming edge will do.
  always @(negedge clk) begin
    if (reset_n) begin
      check("ev_valid", ev_valid, exp_q.size() != 0);
      check("key_state", key_state, exp_keys);
      if (exp_q.size() != 0 && ev_ready)
        check("event", {ev_code, ev_ext, ev_break}, exp_q.pop_front());
      if (rx_done && mon_push) begin
        if (exp_q.size() < DEPTH) exp_q.push_back(mon_ev);
        else                      exp_err[0] = 1'b1;
        mon_k = key_index(mon_ev);
        if (mon_k >= 0) exp_keys[mon_k] = ~mon_ev[0];
      end
    end
  end

  // Random consumer back-pressure
  initial forever begin
    @(posedge clk);
    #1;
    if (rand_ready) ev_ready = ($urandom_range(0, 1) == 1);
  end

  // ---------------------------------------------------------------- driver
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit completes, input logic [9:0] e,
                           input int gap);
    @(posedge clk);
    #1;
    rx_done  = 1'b1;
    rx_data  = b;
    mon_push = completes;
    mon_ev   = e;
    @(posedge clk);
    #1;
    rx_done  = 1'b0;
    mon_push = 1'b0;
    repeat (gap) @(posedge clk);
  endtask

  task automatic send_key(input logic [7:0] code, input logic ext, input logic brk, input int gap);
    if (ext) send_byte(8'hE0, 1'b0, '0, gap);
    if (brk) send_byte(8'hF0, 1'b0, '0, gap);
    send_byte(code, 1'b1, ev(code, ext, brk), gap);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1;
    clr_status = 1'b1;
    @(posedge clk);
    #1;
    clr_status = 1'b0;
    exp_bat = 1'b0;
    exp_err = '0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_bat"}, bat_ok, exp_bat);
    check({tag, "_err"}, err_flags, exp_err);
  endtask

  logic [7:0] key_pool [12] = '{8'h1C, 8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C,
                                8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h5A};
  logic [7:0] burst    [5]  = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C};

  initial begin
    // Reset state
    #12;
    check("reset_outputs", {ev_valid, ev_code, ev_ext, ev_break, key_state, bat_ok, err_flags}, '0);
    wait_cycles(2);
    reset_n = 1'b1;
    ev_ready = 1'b1;
    wait_cycles(2);

    // Make then break of a plain key
    send_key(8'h1C, 1'b0, 1'b0, 1);
    send_key(8'h1C, 1'b0, 1'b1, 1);
    wait_cycles(3);

    // Extended jog key held then released
    send_key(8'h75, 1'b1, 1'b0, 0);
    wait_cycles(1);
    check("up_held", key_state[0], 1'b1);
    send_key(8'h75, 1'b1, 1'b1, 0);
    wait_cycles(1);
    check("up_released", key_state[0], 1'b0);
    wait_cycles(2);

    // Overflow with a stalled consumer, then drain in order
    ev_ready = 1'b0;
    foreach (burst[i]) send_key(burst[i], 1'b0, 1'b0, 0);
    wait_cycles(2);
    check("ovf_flag", err_flags[0], 1'b1);
    check("ovf_head", ev_code, 8'h15);
    ev_ready = 1'b1;
    wait_cycles(8);
    check("drained", ev_valid, 1'b0);
    check_status("after_ovf");

    // Inter-byte timeout after a lone E0
    send_byte(8'hE0, 1'b0, '0, 0);
    wait_cycles(50);
    check("no_early_timeout", err_flags[1], 1'b0);
    wait_cycles(60);
    exp_err[1] = 1'b1;
    check("timeout_flag", err_flags[1], 1'b1);
    check("timeout_no_event", ev_valid, 1'b0);
    send_key(8'h29, 1'b0, 1'b0, 0);
    wait_cycles(2);
    check("space_held", key_state[4], 1'b1);
    check_status("after_timeout");

    // Status bytes and clear
    pulse_clr();
    check_status("clr1");
    send_byte(8'hAA, 1'b0, '0, 0);
    send_byte(8'hFC, 1'b0, '0, 0);
    send_byte(8'h00, 1'b0, '0, 0);
    exp_bat = 1'b1;
    exp_err = 4'b1100;
    wait_cycles(2);
    check("status_bat", bat_ok, 1'b1);
    check("status_err", err_flags, 4'b1100);
    check("status_no_event", ev_valid, 1'b0);
    pulse_clr();
    wait_cycles(1);
    check("clr_bat", bat_ok, 1'b0);
    check("clr_err", err_flags, 4'b0000);

    // Pause sequence yields one event; BAT flag set so reset has work to do
    send_byte(8'hAA, 1'b0, '0, 0);
    exp_bat = 1'b1;
    send_byte(8'hE1, 1'b0, '0, 0);
    send_byte(8'h14, 1'b0, '0, 0);
    send_byte(8'h77, 1'b0, '0, 0);
    send_byte(8'hE1, 1'b0, '0, 0);
    send_byte(8'hF0, 1'b0, '0, 0);
    send_byte(8'h14, 1'b0, '0, 0);
    send_byte(8'hF0, 1'b0, '0, 0);
    send_byte(8'h77, 1'b1, ev(8'h77, 1'b1, 1'b0), 0);
    wait_cycles(3);
    check("pause_single", ev_valid, 1'b0);

    // Reset in the middle of E0 F0
    send_byte(8'hE0, 1'b0, '0, 0);
    send_byte(8'hF0, 1'b0, '0, 0);
    #3;
    reset_n = 1'b0;
    exp_q.delete();
    exp_keys = '0;
    exp_bat  = 1'b0;
    exp_err  = '0;
    #2;
    check("midseq_reset", {ev_valid, ev_code, ev_ext, ev_break, key_state, bat_ok, err_flags}, '0);
    wait_cycles(2);
    reset_n = 1'b1;
    send_key(8'h1C, 1'b0, 1'b0, 0);
    wait_cycles(3);
    check_status("after_reset");

    // Randomized traffic with random back-pressure
    rand_ready = 1'b1;
    for (int t = 0; t < 300; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        send_byte(8'hE1, 1'b0, '0, $urandom_range(0, 2));
        for (int j = 0; j < 6; j++)
          send_byte(8'($urandom_range(0, 255)), 1'b0, '0, $urandom_range(0, 2));
        send_byte(8'($urandom_range(0, 255)), 1'b1, ev(8'h77, 1'b1, 1'b0), $urandom_range(0, 2));
      end else begin
        send_key(key_pool[$urandom_range(0, 11)], 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3));
      end
    end
    rand_ready = 1'b0;
    wait_cycles(1);
    ev_ready = 1'b1;
    wait_cycles(10);
    check("random_drained", ev_valid, 1'b0);
    check("random_keys", key_state, exp_keys);
    check_status("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

endmodule
